// File: rtl/mem_channel_mux.sv
// mem_channel_mux: serializes per-channel read/write handshakes onto one external memory port,
// round-robin, one transaction in flight, ready held until the owner drops its valid.
module mem_channel_mux #(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_BITS = 8,
  parameter int MEMORY_BUS_BITS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic [NUM_CHANNELS-1:0] mem_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0] mem_read_ready,
  output logic [NUM_CHANNELS-1:0][MEMORY_BUS_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0] mem_write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS-1:0][MEMORY_BUS_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0] mem_write_ready,
  output logic ext_req_valid,
  output logic ext_req_write,
  output logic [ADDR_BITS-1:0] ext_req_addr,
  output logic [MEMORY_BUS_BITS-1:0] ext_req_wdata,
  input  logic ext_req_ready,
  input  logic ext_resp_valid,
  input  logic [MEMORY_BUS_BITS-1:0] ext_resp_rdata
);
  localparam int PW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RELAY} state_t;
  state_t state;
  logic [PW-1:0] rr_ptr, owner, sel, sel_lo, sel_hi, next_ptr;
  logic op_write, found_lo, found_hi, done, owner_valid;
  logic [NUM_CHANNELS-1:0] pending;
  assign pending = mem_read_valid | mem_write_valid;
  // lowest pending channel at or above rr_ptr, else lowest pending overall
  always_comb begin
    found_lo = 1'b0;
    found_hi = 1'b0;
    sel_lo = '0;
    sel_hi = '0;
    for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
      if (pending[c]) begin
        found_lo = 1'b1;
        sel_lo = PW'(c);
        if (PW'(c) >= rr_ptr) begin
          found_hi = 1'b1;
          sel_hi = PW'(c);
        end
      end
    end
    sel = found_hi ? sel_hi : sel_lo;
  end
  assign next_ptr = (owner == PW'(NUM_CHANNELS - 1)) ? '0 : owner + 1'b1;
  assign done = ext_resp_valid && (state == WAIT_RESP || (state == ISSUE && ext_req_ready));
  assign owner_valid = op_write ? mem_write_valid[owner] : mem_read_valid[owner];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      op_write <= 1'b0;
      ext_req_valid <= 1'b0;
      ext_req_write <= 1'b0;
      ext_req_addr <= '0;
      ext_req_wdata <= '0;
      mem_read_ready <= '0;
      mem_write_ready <= '0;
      mem_read_data <= '0;
    end else begin
      if (done) begin
        state <= RELAY;
        rr_ptr <= next_ptr;
        if (op_write) mem_write_ready[owner] <= 1'b1;
        else begin
          mem_read_ready[owner] <= 1'b1;
          mem_read_data[owner] <= ext_resp_rdata;
        end
      end
      case (state)
        IDLE: if (found_lo) begin
          owner <= sel;
          op_write <= !mem_read_valid[sel];
          ext_req_write <= !mem_read_valid[sel];
          ext_req_addr <= mem_read_valid[sel] ? mem_read_address[sel] : mem_write_address[sel];
          ext_req_wdata <= mem_write_data[sel];
          ext_req_valid <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: if (ext_req_ready) begin
          ext_req_valid <= 1'b0;
          if (!ext_resp_valid) state <= WAIT_RESP;
        end
        RELAY: if (!owner_valid) begin
          mem_read_ready <= '0;
          mem_write_ready <= '0;
          state <= IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_channel_mux.sv
// tb_mem_channel_mux: randomized and directed checks of mem_channel_mux against a queue/array reference model.
module tb_mem_channel_mux;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0] rv, wv, mem_read_ready, mem_write_ready;
  logic [N-1:0][7:0] ra, wa, wd, mem_read_data;
  logic ext_req_valid, ext_req_write, ext_req_ready, ext_resp_valid;
  logic [7:0] ext_req_addr, ext_req_wdata, ext_resp_rdata;

  mem_channel_mux #(.NUM_CHANNELS(N), .ADDR_BITS(8), .MEMORY_BUS_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .mem_read_valid(rv), .mem_read_address(ra), .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(wv), .mem_write_address(wa), .mem_write_data(wd), .mem_write_ready(mem_write_ready),
    .ext_req_valid(ext_req_valid), .ext_req_write(ext_req_write), .ext_req_addr(ext_req_addr),
    .ext_req_wdata(ext_req_wdata), .ext_req_ready(ext_req_ready), .ext_resp_valid(ext_resp_valid),
    .ext_resp_rdata(ext_resp_rdata)
  );

  int n_checks = 0;
  int n_fail = 0;
  int acc_lat = 0;
  int resp_lat = 0;
  int resp_count = 0;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [16:0] log_q [$];
  int got_ch [$];
  logic [7:0] got_data [$];
  bit sv_timeout, sv_bad;

  // external memory: accepts after acc_lat cycles, responds resp_lat cycles after accept
  initial begin
    int wait_cnt = 0;
    int cnt = 0;
    bit pend = 0;
    logic [7:0] rdata = '0;
    ext_req_ready = 1'b0;
    ext_resp_valid = 1'b0;
    ext_resp_rdata = '0;
    forever begin
      @(negedge clk);
      ext_req_ready = 1'b0;
      ext_resp_valid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          ext_resp_valid = 1'b1;
          ext_resp_rdata = rdata;
          pend = 0;
          resp_count++;
        end else cnt--;
      end else if (ext_req_valid) begin
        if (wait_cnt >= acc_lat) begin
          wait_cnt = 0;
          ext_req_ready = 1'b1;
          log_q.push_back({ext_req_write, ext_req_addr, ext_req_wdata});
          if (ext_req_write) mem[ext_req_addr] = ext_req_wdata;
          rdata = mem[ext_req_addr];
          if (resp_lat == 0) begin
            ext_resp_valid = 1'b1;
            ext_resp_rdata = rdata;
            resp_count++;
          end else begin
            pend = 1;
            cnt = resp_lat - 1;
          end
        end else wait_cnt++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rv = '0;
    wv = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // drives a set of simultaneous requests as well-behaved channels; rerq channels re-request once at addr+1
  task automatic serve(input logic [N-1:0] rd, input logic [N-1:0] wr, input logic [N-1:0][7:0] addr,
                       input logic [N-1:0][7:0] wdat, input logic [N-1:0] rerq);
    logic [N-1:0] act, re_due, re_done;
    logic rdy, other;
    int base, cyc;
    got_ch.delete();
    got_data.delete();
    sv_timeout = 0;
    sv_bad = 0;
    base = resp_count;
    act = rd | wr;
    re_due = '0;
    re_done = '0;
    ra = addr;
    wa = addr;
    wd = wdat;
    rv = rd;
    wv = wr;
    cyc = 0;
    while ((act | re_due) != '0 && cyc < 300) begin
      tick();
      cyc++;
      if ($countones({mem_read_ready, mem_write_ready}) > 1) sv_bad = 1;
      for (int c = 0; c < N; c++) begin
        rdy = rd[c] ? mem_read_ready[c] : mem_write_ready[c];
        other = rd[c] ? mem_write_ready[c] : mem_read_ready[c];
        if (other || ((mem_read_ready[c] | mem_write_ready[c]) && !act[c])) sv_bad = 1;
        if (re_due[c]) begin
          re_due[c] = 0;
          re_done[c] = 1;
          act[c] = 1;
          ra[c] = ra[c] + 8'd1;
          wa[c] = wa[c] + 8'd1;
          rv[c] = rd[c];
          wv[c] = wr[c];
        end else if (act[c] && rdy) begin
          got_ch.push_back(c);
          got_data.push_back(mem_read_data[c]);
          if (resp_count - base < got_ch.size()) sv_bad = 1;
          rv[c] = 1'b0;
          wv[c] = 1'b0;
          act[c] = 0;
          if (rerq[c] && !re_done[c]) re_due[c] = 1;
        end
      end
    end
    sv_timeout = (act | re_due) != '0;
    rv = '0;
    wv = '0;
    tick();
    if ((mem_read_ready | mem_write_ready) != '0) sv_bad = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (ext_req_valid !== 1'b0 || ext_req_write !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ext_ctrl: got valid=%b write=%b expected 0 0", ext_req_valid, ext_req_write);
    end
    n_checks++;
    if (ext_req_addr !== 8'h00 || ext_req_wdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ext_data: got addr=%h wdata=%h expected 00 00", ext_req_addr, ext_req_wdata);
    end
    n_checks++;
    if (mem_read_ready !== '0 || mem_write_ready !== '0 || mem_read_data !== '0) begin
      n_fail++;
      $display("FAIL reset_channels: got rr=%b wr=%b rdata=%h expected all zero", mem_read_ready, mem_write_ready, mem_read_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    bit seen = 0;
    int cyc = 0;
    mem[8'h3A] = 8'h5C;
    ref_mem[8'h3A] = 8'h5C;
    acc_lat = 0;
    resp_lat = 4;
    log_q.delete();
    ra[2] = 8'h3A;
    rv[2] = 1'b1;
    while (!mem_read_ready[2] && cyc < 30) begin
      tick();
      cyc++;
      if (ext_req_valid && !seen) begin
        seen = 1;
        n_checks++;
        if (ext_req_addr !== 8'h3A || ext_req_write !== 1'b0) begin
          n_fail++;
          $display("FAIL read_ext_req: got addr=%h write=%b expected 3a 0", ext_req_addr, ext_req_write);
        end
      end
    end
    n_checks++;
    if (!seen || mem_read_ready[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL read_complete: got seen=%0d ready=%b expected 1 1", seen, mem_read_ready[2]);
    end
    n_checks++;
    if (mem_read_data[2] !== 8'h5C || mem_read_ready !== 4'b0100 || mem_write_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL read_data: got data=%h rr=%b wr=%b expected 5c 0100 0000", mem_read_data[2], mem_read_ready, mem_write_ready);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (mem_read_ready[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL read_hold_%0d: got ready=%b expected 1", i, mem_read_ready[2]);
      end
    end
    rv[2] = 1'b0;
    tick();
    n_checks++;
    if (mem_read_ready[2] !== 1'b0 || mem_read_data[2] !== 8'h5C) begin
      n_fail++;
      $display("FAIL read_release: got ready=%b data=%h expected 0 5c", mem_read_ready[2], mem_read_data[2]);
    end
    n_checks++;
    if (log_q.size() != 1) begin
      n_fail++;
      $display("FAIL read_ext_count: got %0d expected 1", log_q.size());
    end
  endtask

  task automatic test_single_write();
    bit stray = 0;
    int cyc = 0;
    acc_lat = 1;
    resp_lat = 2;
    log_q.delete();
    wa[0] = 8'h10;
    wd[0] = 8'hA5;
    wv[0] = 1'b1;
    while (!mem_write_ready[0] && cyc < 30) begin
      tick();
      cyc++;
      if (mem_read_ready != '0 || mem_write_ready[3:1] != '0) stray = 1;
    end
    ref_mem[8'h10] = 8'hA5;
    n_checks++;
    if (mem_write_ready !== 4'b0001 || mem_read_ready !== 4'b0000 || stray) begin
      n_fail++;
      $display("FAIL write_ready: got wr=%b rr=%b stray=%0d expected 0001 0000 0", mem_write_ready, mem_read_ready, stray);
    end
    n_checks++;
    if (log_q.size() != 1 || log_q[0] !== {1'b1, 8'h10, 8'hA5}) begin
      n_fail++;
      $display("FAIL write_ext_req: got n=%0d req=%h expected 1 11 0a5", log_q.size(), log_q.size() ? log_q[0] : 17'h0);
    end
    wv[0] = 1'b0;
    tick();
    n_checks++;
    if (mem_write_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL write_release: got %b expected 0000", mem_write_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0][7:0] a;
    int exp_ch [$];
    do_reset();
    acc_lat = 0;
    resp_lat = 0;
    a = {8'h33, 8'h22, 8'h11, 8'h00};
    for (int pass = 0; pass < 2; pass++) begin
      log_q.delete();
      serve(4'b1111, 4'b0000, a, '0, pass ? 4'b0001 : 4'b0000);
      exp_ch = pass ? '{0, 1, 2, 3, 0} : '{0, 1, 2, 3};
      n_checks++;
      if (sv_timeout || sv_bad || got_ch.size() != exp_ch.size() || log_q.size() != exp_ch.size()) begin
        n_fail++;
        $display("FAIL rr_pass%0d_status: got timeout=%0d bad=%0d done=%0d ext=%0d expected 0 0 %0d %0d",
                 pass, sv_timeout, sv_bad, got_ch.size(), log_q.size(), exp_ch.size(), exp_ch.size());
      end else begin
        for (int k = 0; k < exp_ch.size(); k++) begin
          logic [7:0] ea;
          ea = 8'(exp_ch[k] * 8'h11) + ((pass && k == 4) ? 8'd1 : 8'd0);
          n_checks++;
          if (got_ch[k] != exp_ch[k] || log_q[k][15:8] !== ea || log_q[k][16] !== 1'b0 || got_data[k] !== ref_mem[ea]) begin
            n_fail++;
            $display("FAIL rr_pass%0d_slot%0d: got ch=%0d addr=%h data=%h expected ch=%0d addr=%h data=%h",
                     pass, k, got_ch[k], log_q[k][15:8], got_data[k], exp_ch[k], ea, ref_mem[ea]);
          end
        end
      end
    end
  endtask

  task automatic test_chunk();
    logic [N-1:0][7:0] a;
    acc_lat = 0;
    resp_lat = 3;
    log_q.delete();
    a = '0;
    a[1] = 8'h40;
    serve(4'b0010, 4'b0000, a, '0, 4'b0010);
    n_checks++;
    if (sv_timeout || sv_bad || got_ch.size() != 2 || log_q.size() != 2) begin
      n_fail++;
      $display("FAIL chunk_status: got timeout=%0d bad=%0d done=%0d ext=%0d expected 0 0 2 2",
               sv_timeout, sv_bad, got_ch.size(), log_q.size());
    end else begin
      n_checks++;
      if (log_q[0][15:8] !== 8'h40 || log_q[1][15:8] !== 8'h41 || log_q[0][16] || log_q[1][16]) begin
        n_fail++;
        $display("FAIL chunk_order: got %h,%h expected read 40 then read 41", log_q[0], log_q[1]);
      end
      n_checks++;
      if (got_data[0] !== ref_mem[8'h40] || got_data[1] !== ref_mem[8'h41] || got_ch[0] != 1 || got_ch[1] != 1) begin
        n_fail++;
        $display("FAIL chunk_data: got %h,%h expected %h,%h", got_data[0], got_data[1], ref_mem[8'h40], ref_mem[8'h41]);
      end
    end
  endtask

  task automatic test_backpressure();
    int held = 0;
    int cyc = 0;
    bit unstable = 0;
    acc_lat = 5;
    resp_lat = 1;
    log_q.delete();
    wa[3] = 8'h77;
    wd[3] = 8'h3C;
    wv[3] = 1'b1;
    while (!mem_write_ready[3] && cyc < 40) begin
      tick();
      cyc++;
      if (ext_req_valid) begin
        held++;
        if (ext_req_addr !== 8'h77 || ext_req_wdata !== 8'h3C || ext_req_write !== 1'b1) unstable = 1;
      end
    end
    ref_mem[8'h77] = 8'h3C;
    n_checks++;
    if (held != 6 || unstable) begin
      n_fail++;
      $display("FAIL bp_hold: got valid_cycles=%0d unstable=%0d expected 6 0", held, unstable);
    end
    n_checks++;
    if (mem_write_ready[3] !== 1'b1 || log_q.size() != 1) begin
      n_fail++;
      $display("FAIL bp_accept: got ready=%b accepts=%0d expected 1 1", mem_write_ready[3], log_q.size());
    end
    wv[3] = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    int cyc = 0;
    bit stray = 0;
    acc_lat = 0;
    resp_lat = 8;
    log_q.delete();
    ra[1] = 8'h05;
    rv[1] = 1'b1;
    while (log_q.size() == 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (ext_req_valid !== 1'b0 || mem_read_ready !== '0 || mem_write_ready !== '0 || mem_read_data !== '0 || log_q.size() != 1) begin
      n_fail++;
      $display("FAIL areset_immediate: got ev=%b rr=%b wr=%b rdata=%h accepts=%0d expected 0 0 0 0 1",
               ext_req_valid, mem_read_ready, mem_write_ready, mem_read_data, log_q.size());
    end
    tick();
    reset = 1'b0;
    rv = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (mem_read_ready != '0 || mem_write_ready != '0 || ext_req_valid) stray = 1;
    end
    n_checks++;
    if (stray) begin
      n_fail++;
      $display("FAIL areset_late_resp: got activity=1 expected 0");
    end
  endtask

  task automatic test_random();
    logic [N-1:0] rd, wr;
    logic [N-1:0][7:0] addr, wdat;
    int exp_ch [$];
    int ref_ptr = 0;
    for (int r = 0; r < 25; r++) begin
      rd = N'($urandom);
      wr = N'($urandom);
      if ((rd | wr) == '0) rd[$urandom_range(0, N - 1)] = 1'b1;
      for (int c = 0; c < N; c++) begin
        addr[c] = 8'h80 | 8'($urandom);
        wdat[c] = 8'($urandom);
      end
      acc_lat = $urandom_range(0, 2);
      resp_lat = $urandom_range(0, 3);
      exp_ch.delete();
      for (int k = 0; k < N; k++)
        if (rd[(ref_ptr + k) % N] | wr[(ref_ptr + k) % N]) exp_ch.push_back((ref_ptr + k) % N);
      ref_ptr = (exp_ch[exp_ch.size() - 1] + 1) % N;
      log_q.delete();
      serve(rd, wr, addr, wdat, '0);
      n_checks++;
      if (sv_timeout || sv_bad || got_ch.size() != exp_ch.size() || log_q.size() != exp_ch.size()) begin
        n_fail++;
        $display("FAIL rand%0d_status: got timeout=%0d bad=%0d done=%0d ext=%0d expected 0 0 %0d %0d",
                 r, sv_timeout, sv_bad, got_ch.size(), log_q.size(), exp_ch.size(), exp_ch.size());
      end else begin
        for (int k = 0; k < exp_ch.size(); k++) begin
          int c;
          logic [16:0] er;
          logic [7:0] ed;
          c = exp_ch[k];
          er = {!rd[c], addr[c], rd[c] ? log_q[k][7:0] : wdat[c]};
          if (!rd[c]) ref_mem[addr[c]] = wdat[c];
          ed = rd[c] ? ref_mem[addr[c]] : got_data[k];
          n_checks++;
          if (got_ch[k] != c || log_q[k] !== er || got_data[k] !== ed) begin
            n_fail++;
            $display("FAIL rand%0d_slot%0d: got ch=%0d req=%h data=%h expected ch=%0d req=%h data=%h",
                     r, k, got_ch[k], log_q[k], got_data[k], c, er, ed);
          end
        end
      end
    end
  endtask

  initial begin
    rv = '0;
    wv = '0;
    ra = '0;
    wa = '0;
    wd = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i * 29 + 7);
      ref_mem[i] = 8'(i * 29 + 7);
    end
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_chunk();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
